// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-byte holding buffer, valid/ack handshake and rts flow control
//   baud_clk  in   clock at OVERSAMPLE x bit rate
//   rst       in   asynchronous active-high reset
//   rx        in   serial line, idles high
//   rx_ack    in   consumer takes the held byte
//   data_out  out  last good byte, stable while rx_valid
//   rx_valid  out  holding buffer full
//   rts       out  ready-to-receive, ~rx_valid
//   frame_err out  one-cycle pulse on a 0 stop bit
//   overrun   out  sticky, good byte dropped because the buffer was full
//   Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (one cycle more latency).
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 rts,
    output logic                 frame_err,
    output logic                 overrun
);
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int TW = $clog2(OVERSAMPLE);
    // The start decision lands mid start bit; each later decision is one full bit later.
    localparam logic [TW-1:0] T_START = TW'(OVERSAMPLE / 2 - 1 + MAJ);
    localparam logic [TW-1:0] T_BIT   = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    B_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state;
    logic                 r_sync1, r_sync2, r_prev;
    logic [TW-1:0]        r_tick;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_valid, r_ferr, r_ovr;
    logic                 w_fall, w_sample, w_due, w_good;

    assign w_fall = r_prev & ~r_sync2;
`ifdef UART_RX_MAJORITY_EN
    logic r_prev2;
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) r_prev2 <= 1'b1;
        else     r_prev2 <= r_prev;
    end
    // Votes over the three most recent synchronized samples, deciding on the last one.
    assign w_sample = (r_prev2 & r_prev) | (r_prev2 & r_sync2) | (r_prev & r_sync2);
`else
    assign w_sample = r_sync2;
`endif
    assign w_due  = r_tick == ((r_state == START) ? T_START : T_BIT);
    assign w_good = (r_state == STOP) & w_due & w_sample;

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_ferr  <= 1'b0;
            r_tick  <= r_tick + 1'b1;
            case (r_state)
                IDLE: begin
                    r_tick <= '0;
                    if (w_fall) r_state <= START;
                end
                START: if (w_due) begin
                    r_tick  <= '0;
                    r_bit   <= '0;
                    r_state <= w_sample ? IDLE : DATA;
                end
                DATA: if (w_due) begin
                    r_tick  <= '0;
                    r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == B_LAST) r_state <= STOP;
                end
                STOP: if (w_due) begin
                    r_tick  <= '0;
                    r_state <= IDLE;
                    if (!w_sample) r_ferr <= 1'b1;
                end
            endcase
            // A good stop with an ack on the same edge replaces the byte and leaves overrun alone.
            if (w_good) begin
                if (!r_valid || rx_ack) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (rx_ack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign rx_valid  = r_valid;
    assign rts       = ~r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
endmodule
